// File: rtl/rv_isa_pkg.sv
// RV32I opcode constants and the packed-immediate record shared by the
// immediate generator and the immediate packer.
package rv_isa_pkg;

  localparam logic [6:0] jtype     = 7'b1101111;
  localparam logic [6:0] itype     = 7'b0010011;
  localparam logic [6:0] imemtype  = 7'b0000011;
  localparam logic [6:0] stype     = 7'b0100011;
  localparam logic [6:0] btype     = 7'b1100011;
  localparam logic [6:0] ultype    = 7'b0110111;
  localparam logic [6:0] uatype    = 7'b0010111;
  localparam logic [6:0] ijalrtype = 7'b1100111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [19:0] inx20;
    logic [11:0] inx12;
    logic        enx20;
    logic        enx12;
    logic        shamt;
    logic        err;
  } pack_entry_t;

  localparam int PACK_W = $bits(pack_entry_t);

  // True when imm[31:msb] are all equal, i.e. imm fits in an (msb+1)-bit
  // two's complement field.
  function automatic logic upper_same(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] hi;
    hi = imm >> msb;
    return (hi == 32'd0) || (hi == (32'hFFFF_FFFF >> msb));
  endfunction

endpackage

// File: rtl/imm_pack_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module imm_pack_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale slots are never visible past empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imm_pack_unit.sv
// Packs a signed 32-bit immediate into the raw inx20/inx12 instruction fields
// for a given opcode, flags unencodable values, and queues results in a FIFO.
module imm_pack_unit
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERRW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [31:0]     in_imm,
  input  logic            in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [19:0]     out_inx20,
  output logic [11:0]     out_inx12,
  output logic            out_enx20,
  output logic            out_enx12,
  output logic            out_shamt,
  output logic            out_err,
  output logic            err_sticky,
  output logic [ERRW-1:0] err_count
);

  pack_entry_t packed_req;
  pack_entry_t head;
  pack_entry_t shown;
  logic        full;
  logic        empty;
  logic        push_fire;

  always_comb begin
    packed_req        = '0;
    packed_req.opcode = in_opcode;
    case (in_opcode)
      ultype, uatype: begin
        packed_req.inx20 = in_imm[31:12];
        packed_req.enx20 = 1'b1;
        packed_req.err   = |in_imm[11:0];
      end
      jtype: begin
        packed_req.inx20 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12]};
        packed_req.enx20 = 1'b1;
        packed_req.err   = !upper_same(in_imm, 20) || in_imm[0];
      end
      itype: begin
        if (in_shamt) begin
          packed_req.inx12 = {7'b0, in_imm[4:0]};
          packed_req.shamt = 1'b1;
          packed_req.err   = |in_imm[31:5];
        end else begin
          packed_req.inx12 = in_imm[11:0];
          packed_req.enx12 = 1'b1;
          packed_req.err   = !upper_same(in_imm, 11);
        end
      end
      imemtype, ijalrtype, stype: begin
        packed_req.inx12 = in_imm[11:0];
        packed_req.enx12 = 1'b1;
        packed_req.err   = !upper_same(in_imm, 11);
      end
      btype: begin
        packed_req.inx12 = {in_imm[12], in_imm[10:5], in_imm[4:1], in_imm[11]};
        packed_req.enx12 = 1'b1;
        packed_req.err   = !upper_same(in_imm, 12) || in_imm[0];
      end
      default: packed_req.err = 1'b1;
    endcase
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push_fire = in_valid && in_ready;

  imm_pack_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PACK_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .pop   (out_ready),
    .din   (packed_req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Data fields read zero whenever nothing is queued.
  assign shown      = out_valid ? head : '0;
  assign out_opcode = shown.opcode;
  assign out_inx20  = shown.inx20;
  assign out_inx12  = shown.inx12;
  assign out_enx20  = shown.enx20;
  assign out_enx12  = shown.enx12;
  assign out_shamt  = shown.shamt;
  assign out_err    = shown.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (push_fire && packed_req.err) begin
      err_sticky <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_pack_unit.sv
// Self-checking bench for imm_pack_unit: directed vector table, backpressure
// and reset sequences, then randomized traffic against a reference model.
module tb_imm_pack_unit;
  import rv_isa_pkg::*;

  localparam int DEPTH = 2;
  localparam int ERRW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [31:0]     in_imm;
  logic            in_shamt;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [19:0]     out_inx20;
  logic [11:0]     out_inx12;
  logic            out_enx20;
  logic            out_enx12;
  logic            out_shamt;
  logic            out_err;
  logic            err_sticky;
  logic [ERRW-1:0] err_count;

  always #5 clk = ~clk;

  imm_pack_unit #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_imm     (in_imm),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_inx20  (out_inx20),
    .out_inx12  (out_inx12),
    .out_enx20  (out_enx20),
    .out_enx12  (out_enx12),
    .out_shamt  (out_shamt),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [31:0] imm;
    logic        sh;
    logic [19:0] x20;
    logic [11:0] x12;
    logic        e20;
    logic        e12;
    logic        shm;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int unsigned mdl_errs;
  logic        mdl_sticky;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic fits(input logic [31:0] imm, input longint lo, input longint hi);
    longint v;
    v = longint'(signed'(imm));
    return (v >= lo) && (v <= hi);
  endfunction

  // Reference packer: encodability from numeric ranges, fields from arithmetic.
  function automatic exp_t ref_pack(input logic [6:0] op, input logic [31:0] imm, input logic sh);
    exp_t e;
    e = '{op: op, imm: imm, sh: sh, x20: '0, x12: '0, e20: 1'b0, e12: 1'b0, shm: 1'b0, err: 1'b0};
    case (op)
      ultype, uatype: begin
        e.e20 = 1'b1;
        e.x20 = 20'(imm / 32'd4096);
        e.err = (imm % 32'd4096) != 0;
      end
      jtype: begin
        e.e20 = 1'b1;
        e.x20 = 20'(((imm >> 20) % 2) * 524288 + ((imm >> 1) % 1024) * 512
                    + ((imm >> 11) % 2) * 256 + ((imm >> 12) % 256));
        e.err = !(fits(imm, -1048576, 1048575) && (imm % 2) == 0);
      end
      btype: begin
        e.e12 = 1'b1;
        e.x12 = 12'(((imm >> 12) % 2) * 2048 + ((imm >> 5) % 64) * 32
                    + ((imm >> 1) % 16) * 2 + ((imm >> 11) % 2));
        e.err = !(fits(imm, -4096, 4095) && (imm % 2) == 0);
      end
      itype, imemtype, ijalrtype, stype: begin
        if (op == itype && sh) begin
          e.shm = 1'b1;
          e.x12 = 12'(imm % 32'd32);
          e.err = imm >= 32'd32;
        end else begin
          e.e12 = 1'b1;
          e.x12 = 12'(imm % 32'd4096);
          e.err = !fits(imm, -2048, 2047);
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Immediate generator (decoder side) for the round-trip check.
  function automatic logic [31:0] gen_imm(input logic [6:0] op, input logic [19:0] x20,
                                          input logic [11:0] x12, input logic shm);
    logic [20:0] j;
    logic [12:0] b;
    j = {x20[19], x20[7:0], x20[8], x20[18:9], 1'b0};
    b = {x12[11], x12[0], x12[10:1], 1'b0};
    if (op == ultype || op == uatype) return {x20, 12'b0};
    if (op == jtype) return {{11{j[20]}}, j};
    if (op == btype) return {{19{b[12]}}, b};
    if (shm) return {20'b0, x12};
    return {{20{x12[11]}}, x12};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {21'b0, out_opcode, out_inx20, out_inx12, out_enx20, out_enx12, out_shamt, out_err};
  endfunction

  function automatic logic [63:0] exp_vec(input exp_t e);
    return {21'b0, e.op, e.x20, e.x12, e.e20, e.e12, e.shm, e.err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Check the current cycle against the model, then advance the model and
  // the clock by one edge. Entered and left at posedge + 1.
  task automatic step(input string tag);
    logic do_push;
    logic do_pop;
    exp_t e;
    #1;
    check({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    check({tag, ":out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check({tag, ":head"}, dut_vec(), exp_vec(q[0]));
      if (!q[0].err)
        check({tag, ":roundtrip"}, 64'(gen_imm(out_opcode, out_inx20, out_inx12, out_shamt)),
              64'(q[0].imm));
    end else begin
      check({tag, ":idle_zero"}, dut_vec(), 64'd0);
    end
    check({tag, ":err_count"}, 64'(err_count), 64'(mdl_errs));
    check({tag, ":err_sticky"}, 64'(err_sticky), 64'(mdl_sticky));
    do_pop  = out_ready && (q.size() > 0);
    do_push = in_valid && (q.size() < DEPTH);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e = ref_pack(in_opcode, in_imm, in_shamt);
      q.push_back(e);
      if (e.err) begin
        mdl_sticky = 1'b1;
        if (mdl_errs < (1 << ERRW) - 1) mdl_errs++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] imm, input logic sh);
    in_opcode = op;
    in_imm    = imm;
    in_shamt  = sh;
    in_valid  = 1'b1;
  endtask

  exp_t        vecs[14];
  logic [6:0]  ops[9];
  logic [31:0] rimm;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_imm = '0; in_shamt = 1'b0; out_ready = 1'b0;
    mdl_errs = 0; mdl_sticky = 1'b0;

    vecs[0]  = '{imemtype,  32'hFFFF_F800, 1'b0, 20'h0,     12'h800, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = ref_pack(jtype, 32'h000F_F7FE, 1'b0);
    vecs[2]  = '{jtype,     32'h0010_0000, 1'b0, 20'h80000, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{btype,     32'hFFFF_F000, 1'b0, 20'h0,     12'h800, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{btype,     32'h0000_0003, 1'b0, 20'h0,     12'h002, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{itype,     32'd31,        1'b1, 20'h0,     12'h01F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{itype,     32'd32,        1'b1, 20'h0,     12'h000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{ultype,    32'h1234_5000, 1'b0, 20'h12345, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{uatype,    32'h1234_5001, 1'b0, 20'h12345, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{stype,     32'h0000_07FF, 1'b0, 20'h0,     12'h7FF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{stype,     32'h0000_0800, 1'b0, 20'h0,     12'h800, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{ijalrtype, 32'hFFFF_FFFF, 1'b1, 20'h0,     12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{7'b0110011, 32'h0000_0004, 1'b0, 20'h0,    12'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{itype,     32'hFFFF_F7FF, 1'b0, 20'h0,     12'h7FF, 1'b0, 1'b1, 1'b0, 1'b1};
    ops = '{jtype, itype, imemtype, stype, btype, ultype, uatype, ijalrtype, 7'b1110011};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset:out_valid", 64'(out_valid), 64'd0);
    check("reset:in_ready", 64'(in_ready), 64'd1);
    check("reset:err_count", 64'(err_count), 64'd0);
    check("reset:err_sticky", 64'(err_sticky), 64'd0);
    check("reset:fields", dut_vec(), 64'd0);

    // Directed table: one push, visible right after the push edge, then popped.
    for (int i = 0; i < 14; i++) begin
      out_ready = 1'b1;
      drive(vecs[i].op, vecs[i].imm, vecs[i].sh);
      step($sformatf("vec%0d_push", i));
      in_valid = 1'b0;
      check($sformatf("vec%0d:latency", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d:fields", i), dut_vec(), exp_vec(vecs[i]));
      step($sformatf("vec%0d_pop", i));
    end
    check("j_roundtrip", 64'(gen_imm(jtype, vecs[1].x20, 12'h0, 1'b0)), 64'h000F_F7FE);

    // Backpressure: third request must stall until space frees up.
    out_ready = 1'b0;
    drive(imemtype, 32'd1, 1'b0); step("bp_a");
    drive(stype, 32'd2, 1'b0);    step("bp_b");
    drive(btype, 32'd4, 1'b0);
    #1 check("bp:in_ready_full", 64'(in_ready), 64'd0);
    step("bp_c_stall");
    step("bp_c_stall2");
    out_ready = 1'b1;
    step("bp_pop_a");
    step("bp_pop_b_push_c");
    in_valid = 1'b0;
    step("bp_pop_c");
    step("bp_empty");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 5)
        0: rimm = 32'($urandom_range(0, 10000)) - 32'd5000;
        1: rimm = 32'($urandom_range(0, 40));
        2: rimm = $urandom;
        3: rimm = $urandom << 12;
        default: rimm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      if ($urandom % 4 != 0) drive(ops[$urandom % 9], rimm, 1'($urandom % 2));
      else in_valid = 1'b0;
      out_ready = ($urandom % 3) != 0;
      if (n >= 380) begin
        in_valid = 1'b1;
        out_ready = 1'b1;
      end
      step("rand");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step("rand_drain");

    // Reset with entries queued, including an error entry.
    out_ready = 1'b0;
    drive(7'b0110011, 32'd0, 1'b0); step("rq_a");
    drive(imemtype, 32'd5, 1'b0);   step("rq_b");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid:out_valid", 64'(out_valid), 64'd0);
    check("rst_mid:err_count", 64'(err_count), 64'd0);
    check("rst_mid:err_sticky", 64'(err_sticky), 64'd0);
    check("rst_mid:in_ready", 64'(in_ready), 64'd1);
    q.delete();
    mdl_errs = 0;
    mdl_sticky = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(stype, 32'hFFFF_FFF0, 1'b0);
    step("post_rst_push");
    in_valid = 1'b0;
    step("post_rst_pop");
    check("post_rst:alone", 64'(out_valid), 64'd0);
    step("post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
